// File: rtl/mitchell_mult_pipe_pkg.sv
`default_nettype none
// ============================================================================
// mitchell_mult_pipe_pkg : shared widths for the Mitchell log-multiplier pipe
// Rev 1.0
// ============================================================================
package mitchell_mult_pipe_pkg;

  localparam int BW_DEFAULT = 8;

  function automatic int kw_of(input int bw);
    return $clog2(bw);
  endfunction

  function automatic int frac_w(input int bw);
    return bw - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mitchell_mult_pipe_if.sv
`default_nettype none
// ============================================================================
// mitchell_mult_pipe_if : operand/result handshake bundle for the multiplier
// Rev 1.0
// ============================================================================
interface mitchell_mult_pipe_if
  import mitchell_mult_pipe_pkg::*;
#(
  parameter int BW = BW_DEFAULT
);

  logic [BW-1:0]   in_a;
  logic [BW-1:0]   lod_a;
  logic [BW-1:0]   in_b;
  logic [BW-1:0]   lod_b;
  logic            in_valid;
  logic            in_ready;
  logic [2*BW-1:0] out_p;
  logic            out_valid;
  logic            out_ready;
  logic            lod_err;

  modport master (
    output in_a, lod_a, in_b, lod_b, in_valid, out_ready,
    input  in_ready, out_p, out_valid, lod_err
  );

  modport slave (
    input  in_a, lod_a, in_b, lod_b, in_valid, out_ready,
    output in_ready, out_p, out_valid, lod_err
  );

endinterface
`default_nettype wire

// File: rtl/mitchell_mult_pipe_onehot_enc.sv
`default_nettype none
// ============================================================================
// onehot_enc : leading-one vector to binary position, with legality flags
// Rev 1.0
// ============================================================================
module onehot_enc
  import mitchell_mult_pipe_pkg::*;
#(
  parameter int BW = BW_DEFAULT,
  parameter int KW = kw_of(BW)
) (
  input  logic [BW-1:0] operand,
  input  logic [BW-1:0] onehot,
  output logic [KW-1:0] pos,
  output logic          valid,
  output logic          malformed
);

  logic [BW-1:0] above_mask;
  logic          is_zero;
  logic          is_single;
  logic          is_msb;

  always_comb begin
    pos = '0;
    for (int i = 0; i < BW; i++) begin
      if (onehot[i]) pos = pos | KW'(i);
    end
    is_zero    = (onehot == '0);
    is_single  = !is_zero && ((onehot & (onehot - 1'b1)) == '0);
    // Bits strictly above the flagged position must be clear in the operand
    above_mask = ~((onehot << 1) - 1'b1);
    is_msb     = ((operand & onehot) != '0) && ((operand & above_mask) == '0);
    valid      = is_single && is_msb;
    malformed  = !is_zero && !(is_single && is_msb);
  end

endmodule
`default_nettype wire

// File: rtl/mitchell_mult_pipe.sv
`default_nettype none
// ============================================================================
// mitchell_mult_pipe : 3-stage Mitchell approximate unsigned multiplier
// Rev 1.0
// ============================================================================
module mitchell_mult_pipe
  import mitchell_mult_pipe_pkg::*;
#(
  parameter int BW = BW_DEFAULT,
  parameter int KW = kw_of(BW)
) (
  input  logic                clk,
  input  logic                rst_n,
  mitchell_mult_pipe_if.slave bus
);

  localparam int FW = frac_w(BW);
  localparam int PW = 3 * BW;

  logic          en;
  logic          accept;
  logic [KW-1:0] k_a, k_b;
  logic          v_a, v_b, m_a, m_b;
  logic [BW-1:0] sh_a, sh_b;
  logic [PW-1:0] wide;

  logic          s1_valid_d, s1_valid_q, s1_zero_d, s1_zero_q;
  logic [KW-1:0] s1_ka_d, s1_ka_q, s1_kb_d, s1_kb_q;
  logic [FW-1:0] s1_fa_d, s1_fa_q, s1_fb_d, s1_fb_q;
  logic          s2_valid_d, s2_valid_q, s2_zero_d, s2_zero_q;
  logic [KW:0]   s2_k_d, s2_k_q;
  logic [BW-1:0] s2_f_d, s2_f_q;
  logic          out_valid_d, out_valid_q;
  logic [2*BW-1:0] out_p_d, out_p_q;
  logic          lod_err_d, lod_err_q;

  onehot_enc #(.BW(BW), .KW(KW)) u_enc_a (
    .operand(bus.in_a), .onehot(bus.lod_a), .pos(k_a), .valid(v_a), .malformed(m_a)
  );

  onehot_enc #(.BW(BW), .KW(KW)) u_enc_b (
    .operand(bus.in_b), .onehot(bus.lod_b), .pos(k_b), .valid(v_b), .malformed(m_b)
  );

  always_comb begin
    en          = bus.out_ready || !out_valid_q;
    accept      = bus.in_valid && en;
    lod_err_d   = lod_err_q || (accept && (m_a || m_b));

    // Normalise each operand so its leading one sits just above the fraction
    sh_a        = bus.in_a << (KW'(FW) - k_a);
    sh_b        = bus.in_b << (KW'(FW) - k_b);
    s1_valid_d  = bus.in_valid;
    s1_zero_d   = !v_a || !v_b;
    s1_ka_d     = k_a;
    s1_kb_d     = k_b;
    s1_fa_d     = sh_a[FW-1:0];
    s1_fb_d     = sh_b[FW-1:0];

    s2_valid_d  = s1_valid_q;
    s2_zero_d   = s1_zero_q;
    s2_k_d      = {1'b0, s1_ka_q} + {1'b0, s1_kb_q};
    s2_f_d      = {1'b0, s1_fa_q} + {1'b0, s1_fb_q};

    // Fraction carry doubles the characteristic instead of adding the implicit one
    if (!s2_f_q[BW-1]) wide = PW'({1'b1, s2_f_q[FW-1:0]}) << s2_k_q;
    else               wide = PW'(s2_f_q) << (s2_k_q + 1'b1);
    out_valid_d = s2_valid_q;
    out_p_d     = s2_zero_q ? '0 : wide[FW +: 2*BW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_ka_q     <= '0;
      s1_kb_q     <= '0;
      s1_fa_q     <= '0;
      s1_fb_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_k_q      <= '0;
      s2_f_q      <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      lod_err_q   <= 1'b0;
    end else begin
      lod_err_q <= lod_err_d;
      if (en) begin
        s1_valid_q  <= s1_valid_d;
        s1_zero_q   <= s1_zero_d;
        s1_ka_q     <= s1_ka_d;
        s1_kb_q     <= s1_kb_d;
        s1_fa_q     <= s1_fa_d;
        s1_fb_q     <= s1_fb_d;
        s2_valid_q  <= s2_valid_d;
        s2_zero_q   <= s2_zero_d;
        s2_k_q      <= s2_k_d;
        s2_f_q      <= s2_f_d;
        out_valid_q <= out_valid_d;
        out_p_q     <= out_p_d;
      end
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = out_p_q;
  assign bus.lod_err   = lod_err_q;

endmodule
`default_nettype wire
